// File: rtl/multi_lane_aligner_if.sv
// Bus bundle for the multi-lane aligner: shared reference stream, per-lane
// receive words, and the per-lane bitslip / status outputs.
interface multi_lane_aligner_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  logic                     tx_stb;
  logic [WIDTH-1:0]         tx_dat;
  logic [LANES-1:0]         rx_stb;
  logic [LANES*WIDTH-1:0]   rx_dat;
  logic [LANES-1:0]         rx_bitslip;
  logic [LANES-1:0]         locked;
  logic [LANES-1:0]         fail;
  logic [LANES-1:0]         error;
  logic [LANES*16-1:0]      err_cnt;

  // Pattern source / SERDES side: drives data, watches status.
  modport master (
    output tx_stb, tx_dat, rx_stb, rx_dat,
    input  rx_bitslip, locked, fail, error, err_cnt
  );

  // Aligner side.
  modport slave (
    input  tx_stb, tx_dat, rx_stb, rx_dat,
    output rx_bitslip, locked, fail, error, err_cnt
  );
endinterface

// File: rtl/multi_lane_aligner.sv
// Per-lane receive checker and bitslip aligner. Every lane compares its
// received words against the shared reference stream and runs its own
// search/lock machine, slipping the SERDES until the lane matches.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SEARCH | counting good/bad compares, looking for lock or a slip
// ST_WAIT   | bitslip just issued; latches flushed while SERDES settles
// ST_LOCKED | lane aligned; errors counted, too many drop back to search
// ST_FAIL   | slip budget exhausted; terminal until reset
module multi_lane_aligner #(
  parameter int WIDTH       = 8,
  parameter int LANES       = 4,
  parameter int ERROR_COUNT = 8,
  parameter int LOCK_COUNT  = 64,
  parameter int SLIP_WAIT   = 16,
  parameter int MAX_SLIPS   = 2*WIDTH,
  parameter int ERROR_HOLD  = 2500000
) (
  input logic                clk,
  input logic                rst,
  multi_lane_aligner_if.slave bus
);

  localparam int GOOD_W = $clog2(LOCK_COUNT) + 1;
  localparam int BAD_W  = $clog2(ERROR_COUNT) + 1;
  localparam int SLIP_W = $clog2(MAX_SLIPS) + 1;
  localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;
  localparam int HOLD_W = $clog2(ERROR_HOLD) + 1;

  localparam logic [GOOD_W-1:0] GOOD_LIM  = GOOD_W'(LOCK_COUNT);
  localparam logic [BAD_W-1:0]  BAD_LIM   = BAD_W'(ERROR_COUNT);
  localparam logic [SLIP_W-1:0] SLIP_LIM  = SLIP_W'(MAX_SLIPS);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ERROR_HOLD);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  logic [LANES-1:0]    bitslip_v;
  logic [LANES-1:0]    locked_v;
  logic [LANES-1:0]    fail_v;
  logic [LANES-1:0]    error_v;
  logic [LANES*16-1:0] err_cnt_v;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0]  rx_word;
    logic              tx_valid, rx_valid;
    logic [WIDTH-1:0]  tx_q, rx_q;
    logic              flush, consume;
    logic              x_stb, x_err;

    state_t            state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic [BAD_W-1:0]  bad_q, bad_d, bad_inc;
    logic [SLIP_W-1:0] slip_q, slip_d, slip_inc;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              bitslip_q, bitslip_d;
    logic [HOLD_W-1:0] hold_q;

    assign rx_word = bus.rx_dat[i*WIDTH +: WIDTH];
    assign flush   = (state_q == ST_WAIT);
    // A pair is only consumed outside WAIT so nothing sampled mid-slip
    // reaches the compare.
    assign consume = tx_valid & rx_valid & ~flush;

    // One-entry input latches; strobes into a full latch are dropped.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tx_valid <= 1'b0;
        rx_valid <= 1'b0;
        tx_q     <= '0;
        rx_q     <= '0;
      end else if (flush || consume) begin
        tx_valid <= 1'b0;
        rx_valid <= 1'b0;
      end else begin
        if (bus.tx_stb && !tx_valid) begin
          tx_valid <= 1'b1;
          tx_q     <= bus.tx_dat;
        end
        if (bus.rx_stb[i] && !rx_valid) begin
          rx_valid <= 1'b1;
          rx_q     <= rx_word;
        end
      end
    end

    // Registered compare event for the consumed pair.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x_stb <= 1'b0;
        x_err <= 1'b0;
      end else begin
        x_stb <= consume;
        x_err <= consume && (rx_q != tx_q);
      end
    end

    // FSM state and per-lane counters.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= ST_SEARCH;
        good_q    <= '0;
        bad_q     <= '0;
        slip_q    <= '0;
        wait_q    <= '0;
        err_cnt_q <= '0;
        bitslip_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        good_q    <= good_d;
        bad_q     <= bad_d;
        slip_q    <= slip_d;
        wait_q    <= wait_d;
        err_cnt_q <= err_cnt_d;
        bitslip_q <= bitslip_d;
      end
    end

    // Next-state, counter updates and the bitslip pulse.
    always_comb begin
      state_d   = state_q;
      good_d    = good_q;
      bad_d     = bad_q;
      slip_d    = slip_q;
      wait_d    = wait_q;
      err_cnt_d = err_cnt_q;
      bitslip_d = 1'b0;
      good_inc  = good_q + GOOD_W'(1);
      bad_inc   = bad_q + BAD_W'(1);
      slip_inc  = slip_q + SLIP_W'(1);

      case (state_q)
        ST_SEARCH: begin
          if (x_stb) begin
            if (x_err) begin
              good_d = '0;
              bad_d  = bad_inc;
              if (bad_inc == BAD_LIM) begin
                if (slip_inc < SLIP_LIM) begin
                  state_d   = ST_WAIT;
                  bitslip_d = 1'b1;
                  slip_d    = slip_inc;
                  wait_d    = WAIT_LOAD;
                  bad_d     = '0;
                end else begin
                  state_d = ST_FAIL;
                end
              end
            end else begin
              good_d = good_inc;
              if (good_inc == GOOD_LIM) begin
                state_d = ST_LOCKED;
                good_d  = '0;
                bad_d   = '0;
              end
            end
          end
        end

        ST_WAIT: begin
          if (wait_q == '0) begin
            state_d = ST_SEARCH;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end

        ST_LOCKED: begin
          if (x_stb) begin
            if (x_err) begin
              bad_d = bad_inc;
              if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
              end
              if (bad_inc == BAD_LIM) begin
                state_d = ST_SEARCH;
                good_d  = '0;
                bad_d   = '0;
                slip_d  = '0;
              end
            end else begin
              good_d = good_inc;
              // A full window of good words forgives earlier errors.
              if (good_inc == GOOD_LIM) begin
                good_d = '0;
                bad_d  = '0;
              end
            end
          end
        end

        ST_FAIL: begin
        end

        default: state_d = ST_SEARCH;
      endcase
    end

    // Error-hold timer: reloads on any errored compare outside WAIT.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_q <= '0;
      end else if (x_stb && x_err && (state_q != ST_WAIT)) begin
        hold_q <= HOLD_LOAD;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HOLD_W'(1);
      end
    end

    assign bitslip_v[i]          = bitslip_q;
    assign locked_v[i]           = (state_q == ST_LOCKED);
    assign fail_v[i]             = (state_q == ST_FAIL);
    assign error_v[i]            = (hold_q != '0);
    assign err_cnt_v[i*16 +: 16] = err_cnt_q;
  end

  assign bus.rx_bitslip = bitslip_v;
  assign bus.locked     = locked_v;
  assign bus.fail       = fail_v;
  assign bus.error      = error_v;
  assign bus.err_cnt    = err_cnt_v;

endmodule
